// File: rtl/vga_fbuff_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, host writes queue in a FIFO.
// Define VGA_FBUFF_WR_BLANK_ONLY_EN to drain host writes only while blank_i is high.
module vga_fbuff_arbiter #(
    parameter int unsigned fbuff_addr_width_g = 15,
    parameter int unsigned fbuff_data_width_g = 48,
    parameter int unsigned fbuff_latency_g    = 1,
    parameter int unsigned wr_fifo_depth_g    = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rd_req_i,
    input  logic [fbuff_addr_width_g-1:0]     rd_addr_i,
    output logic                              rd_rsp_o,
    output logic [fbuff_data_width_g-1:0]     rd_data_o,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [fbuff_addr_width_g-1:0]     wr_addr_i,
    input  logic [fbuff_data_width_g-1:0]     wr_data_i,
    input  logic                              blank_i,
    output logic                              mem_en_o,
    output logic                              mem_we_o,
    output logic [fbuff_addr_width_g-1:0]     mem_addr_o,
    output logic [fbuff_data_width_g-1:0]     mem_din_o,
    input  logic [fbuff_data_width_g-1:0]     mem_dout_i,
    output logic [$clog2(wr_fifo_depth_g):0]  wr_fifo_lvl_o
);

    localparam int unsigned PtrW = $clog2(wr_fifo_depth_g);
    localparam int unsigned LvlW = PtrW + 1;

    logic [fbuff_addr_width_g-1:0] r_fifo_addr [wr_fifo_depth_g];
    logic [fbuff_data_width_g-1:0] r_fifo_data [wr_fifo_depth_g];
    logic [PtrW-1:0]               r_wr_ptr;
    logic [PtrW-1:0]               r_rd_ptr;
    logic [LvlW-1:0]               r_lvl;

    logic                          r_mem_en;
    logic                          r_mem_we;
    logic [fbuff_addr_width_g-1:0] r_mem_addr;
    logic [fbuff_data_width_g-1:0] r_mem_din;
    logic [fbuff_latency_g-1:0]    r_rd_pipe;
    logic                          r_rd_rsp;
    logic [fbuff_data_width_g-1:0] r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_issue_rd;
    logic w_issue_wr;
    logic w_drain_ok;

`ifdef VGA_FBUFF_WR_BLANK_ONLY_EN
    assign w_drain_ok = blank_i;
`else
    logic w_unused_blank;
    assign w_unused_blank = blank_i;
    assign w_drain_ok     = 1'b1;
`endif

    assign w_full     = (r_lvl == LvlW'(wr_fifo_depth_g));
    assign w_empty    = (r_lvl == '0);
    assign wr_ready_o = ~w_full & ~rst_i;
    assign w_push     = wr_valid_i & wr_ready_o;

    // Reads pre-empt writes unconditionally; the FIFO only drains on otherwise idle cycles.
    assign w_issue_rd = rd_req_i;
    assign w_issue_wr = ~rd_req_i & ~w_empty & w_drain_ok;
    assign w_pop      = w_issue_wr;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr_i;
            r_fifo_data[r_wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rd_pipe  <= '0;
            r_rd_rsp   <= 1'b0;
            r_rd_data  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lvl      <= '0;
        end else begin
            r_mem_en <= w_issue_rd | w_issue_wr;
            r_mem_we <= w_issue_wr;
            if (w_issue_rd) begin
                r_mem_addr <= rd_addr_i;
            end else if (w_issue_wr) begin
                r_mem_addr <= r_fifo_addr[r_rd_ptr];
                r_mem_din  <= r_fifo_data[r_rd_ptr];
            end

            // Stage 0 tracks the read already on the port, so the last stage lines up with dout.
            r_rd_pipe[0] <= r_mem_en & ~r_mem_we;
            for (int i = 1; i < int'(fbuff_latency_g); i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
            r_rd_rsp <= r_rd_pipe[fbuff_latency_g-1];
            if (r_rd_pipe[fbuff_latency_g-1]) begin
                r_rd_data <= mem_dout_i;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_lvl <= r_lvl + LvlW'(1);
            end else if (!w_push && w_pop) begin
                r_lvl <= r_lvl - LvlW'(1);
            end
        end
    end

    assign mem_en_o      = r_mem_en;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_mem_addr;
    assign mem_din_o     = r_mem_din;
    assign rd_rsp_o      = r_rd_rsp;
    assign rd_data_o     = r_rd_data;
    assign wr_fifo_lvl_o = r_lvl;

endmodule

// File: doc/vga_fbuff_arbiter.md
# vga_fbuff_arbiter

Single-port arbiter between the display read path and a host write path for the VGA frame buffer. Accepts tile-row read requests from `vga_line_buffers`, buffers host writes in a small FIFO, and drives the one port of `vga_frame_buffer`. Display reads always take priority so line-buffer fills meet their deadline. Host writes drain only in cycles where no read is being issued.

## Interface
- `fbuff_addr_width_g`, 15, frame-buffer address width.
- `fbuff_data_width_g`, 48, frame-buffer row width (4 tiles × 12 bit).
- `fbuff_latency_g`, 1, memory read latency in cycles, range 1..4.
- `wr_fifo_depth_g`, 8, host write FIFO entries, power of 2, ≥2.

Ports:
- `clk_i`  in  1  pixel clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `rd_req_i`  in  1  display read request, one request per high cycle.
- `rd_addr_i`  in  `fbuff_addr_width_g`  display read address.
- `rd_rsp_o`  out  1  one-cycle pulse; `rd_data_o` valid.
- `rd_data_o`  out  `fbuff_data_width_g`  read data, registered.
- `wr_valid_i`  in  1  host write valid.
- `wr_ready_o`  out  1  FIFO can accept; transfer when valid & ready.
- `wr_addr_i`  in  `fbuff_addr_width_g`  host write address.
- `wr_data_i`  in  `fbuff_data_width_g`  host write data.
- `blank_i`  in  1  vertical blanking indicator (used only with macro).
- `mem_en_o`  out  1  memory enable, registered.
- `mem_we_o`  out  1  memory write enable, registered.
- `mem_addr_o`  out  `fbuff_addr_width_g`  memory address, registered.
- `mem_din_o`  out  `fbuff_data_width_g`  memory write data, registered.
- `mem_dout_i`  in  `fbuff_data_width_g`  memory read data.
- `wr_fifo_lvl_o`  out  `$clog2(wr_fifo_depth_g)+1`  FIFO occupancy.

## Operation
- Reset values: all registered outputs are 0. `wr_ready_o` is 0 while `rst_i` is high. The FIFO is empty and the read pipeline is cleared.
- Issue decision is made each cycle from sampled inputs:
  - If `rd_req_i` is high, issue READ.
  - Otherwise, if the FIFO is non-empty (and the drain is permitted), issue WRITE by popping the head entry.
  - Otherwise, IDLE.
- READ: `mem_en_o`=1, `mem_we_o`=0, `mem_addr_o`=`rd_addr_i`. A valid bit enters a shift register of length `fbuff_latency_g`.
- WRITE: `mem_en_o`=1, `mem_we_o`=1, `mem_addr_o`/`mem_din_o` take the FIFO head.
- IDLE: `mem_en_o`=0, `mem_we_o`=0; address and data hold their values.
- Read response: when the shifted valid bit emerges, `rd_data_o` captures `mem_dout_i` and `rd_rsp_o` pulses for one cycle.
- Reads are fully pipelined: back-to-back `rd_req_i` gives back-to-back responses, in order.
- FIFO:
  - `wr_ready_o` = !full.
  - Push and pop in the same cycle leaves the level unchanged.
  - There is no bypass: a pushed entry is eligible for a pop from the next cycle.
- No read/write forwarding. A read of an address with a pending FIFO write returns the current memory contents.

## Timing
- Read latency: `rd_req_i` sampled in cycle N gives `mem_en_o` in N+1 and `rd_rsp_o` in N+2+`fbuff_latency_g`. This is 3 cycles at the default latency.
- Write: accept in cycle N gives the earliest `mem_we_o` in N+2 (push at N, pop decision at N+1, registered output at N+2).
- Full: the 8th accepted write with no pops drops `wr_ready_o` the next cycle. `wr_valid_i` while ready is low is ignored.
- Level counter wraps never. Pointers wrap modulo `wr_fifo_depth_g`.
- Continuous `rd_req_i` starves writes indefinitely. This is intended: display has absolute priority.
- Reset mid-operation:
  - In-flight reads are discarded and produce no `rd_rsp_o`.
  - FIFO contents are lost.
  - A `mem_we_o` already on the port completes, and is deasserted in the first reset cycle.

## Configuration
- Macro `VGA_FBUFF_WR_BLANK_ONLY_EN`.
- Defined: WRITE is issued only when `blank_i`=1 (tear-free updates). Outside blanking the FIFO only fills.
- Undefined: `blank_i` is ignored, and writes drain in any cycle without a read.

## Test plan
- Reset, then a single `rd_req_i` at addr 0x0005 with memory row 0x0005 = 0xABC…: `rd_rsp_o` pulses exactly 3 cycles later, `rd_data_o` = memory row, exactly one pulse.
- 4 consecutive `rd_req_i` (addrs 0..3): 4 consecutive `rd_rsp_o` pulses, data in address order, no gaps.
- 9 writes pushed while `rd_req_i` is held high: `wr_ready_o` drops after 8 accepts, `wr_fifo_lvl_o`=8, no `mem_we_o`. Release reads: 8 writes drain in FIFO order, level returns to 0, readback matches.
- Write to addr 0x10 and `rd_req_i` to addr 0x20 presented in the same cycle: the read is issued first, the write follows the next cycle, and the read data is unaffected.
- With `VGA_FBUFF_WR_BLANK_ONLY_EN` and `blank_i`=0: 3 writes queue, level=3, no `mem_we_o`. Raise `blank_i`: 3 writes issue on consecutive cycles. Without the macro, the writes drain immediately.
- Assert `rst_i` one cycle after `rd_req_i` with the FIFO holding 2 entries: no `rd_rsp_o`, level=0, `wr_ready_o`=0 during reset and 1 after.
